// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports and the data-memory pins seen by dmem_arbiter.
// The arbiter takes the slave view; requesters plus the memory take the master view.
interface dmem_arbiter_if;
    logic        req0;
    logic        req1;
    logic        we0;
    logic        we1;
    logic [31:0] addr0;
    logic [31:0] addr1;
    logic [31:0] wdata0;
    logic [31:0] wdata1;
    logic        gnt0;
    logic        gnt1;
    logic        done0;
    logic        done1;
    logic        err0;
    logic        err1;
    logic [31:0] rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_rdata;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        output gnt0, gnt1, done0, done1, err0, err1, rdata,
               mem_addr, mem_wdata, mem_write, mem_read
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        input  gnt0, gnt1, done0, done1, err0, err1, rdata,
               mem_addr, mem_wdata, mem_write, mem_read
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter in front of a 32-word data memory.
// Each access runs IDLE -> ACCESS (grant, strobe) -> RESP (done/err), with window checking.
module dmem_arbiter #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0080,
    parameter int unsigned DEPTH     = 32
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e      state_q;
    logic        winner_q;
    logic        last_winner_q;
    logic        range_ok_q;
    logic [1:0]  gnt_q;
    logic [1:0]  done_q;
    logic [1:0]  err_q;
    logic [31:0] rdata_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic        mem_wr_q;
    logic        mem_rd_q;

    logic        any_req;
    logic        winner_d;
    logic        we_d;
    logic [31:0] addr_d;
    logic [31:0] wdata_d;
    logic        range_ok_d;
    logic [32:0] addr_ext;
    logic [32:0] lo_ext;
    logic [32:0] hi_ext;

    // 33-bit compare so an address near the top of the space cannot wrap into the window.
    always_comb begin
        any_req    = bus.req0 | bus.req1;
        winner_d   = (bus.req0 & bus.req1) ? ~last_winner_q : bus.req1;
        we_d       = winner_d ? bus.we1 : bus.we0;
        addr_d     = winner_d ? bus.addr1 : bus.addr0;
        wdata_d    = winner_d ? bus.wdata1 : bus.wdata0;
        addr_ext   = {1'b0, addr_d};
        lo_ext     = {1'b0, BASE_ADDR};
        hi_ext     = lo_ext + (33'(DEPTH) << 2);
        range_ok_d = (addr_d[1:0] == 2'b00) && (addr_ext >= lo_ext) && (addr_ext < hi_ext);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= StIdle;
            winner_q      <= 1'b0;
            last_winner_q <= 1'b1;
            range_ok_q    <= 1'b0;
            gnt_q         <= 2'b00;
            done_q        <= 2'b00;
            err_q         <= 2'b00;
            rdata_q       <= 32'h0;
            mem_addr_q    <= 32'h0;
            mem_wdata_q   <= 32'h0;
            mem_wr_q      <= 1'b0;
            mem_rd_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    done_q <= 2'b00;
                    err_q  <= 2'b00;
                    if (any_req) begin
                        winner_q    <= winner_d;
                        range_ok_q  <= range_ok_d;
                        gnt_q       <= winner_d ? 2'b10 : 2'b01;
                        mem_addr_q  <= addr_d;
                        mem_wdata_q <= wdata_d;
                        mem_wr_q    <= we_d & range_ok_d;
                        mem_rd_q    <= ~we_d & range_ok_d;
                        state_q     <= StAccess;
                    end
                end
                StAccess: begin
                    gnt_q       <= 2'b00;
                    mem_addr_q  <= 32'h0;
                    mem_wdata_q <= 32'h0;
                    mem_wr_q    <= 1'b0;
                    mem_rd_q    <= 1'b0;
                    rdata_q     <= mem_rd_q ? bus.mem_rdata : 32'h0;
                    done_q      <= winner_q ? 2'b10 : 2'b01;
                    err_q       <= range_ok_q ? 2'b00 : (winner_q ? 2'b10 : 2'b01);
                    state_q     <= StResp;
                end
                StResp: begin
                    done_q        <= 2'b00;
                    err_q         <= 2'b00;
                    last_winner_q <= winner_q;
                    state_q       <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Strobes are gated by reset so a reset landing on ACCESS never commits a write.
    assign bus.mem_write = mem_wr_q & rst;
    assign bus.mem_read  = mem_rd_q & rst;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.gnt0      = gnt_q[0];
    assign bus.gnt1      = gnt_q[1];
    assign bus.done0     = done_q[0];
    assign bus.done1     = done_q[1];
    assign bus.err0      = err_q[0];
    assign bus.err1      = err_q[1];
    assign bus.rdata     = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a 32-word memory model preloaded with 0x1000_0000 + index.
module tb_dmem_arbiter;

    logic clk;
    logic rst;
    logic preload;
    int   total;
    int   bad;

    logic [31:0] mem [32];
    logic        mem_hit;
    logic [4:0]  mem_idx;

    dmem_arbiter_if bus ();

    dmem_arbiter #(
        .BASE_ADDR (32'h0000_0080),
        .DEPTH     (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        mem_hit       = (bus.mem_addr >= 32'h80) && (bus.mem_addr < 32'h100);
        mem_idx       = 5'((bus.mem_addr - 32'h80) >> 2);
        bus.mem_rdata = mem_hit ? mem[mem_idx] : 32'h0;
    end

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'h1000_0000 + 32'(i);
        end else if (bus.mem_write && mem_hit) begin
            mem[mem_idx] <= bus.mem_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst        = 1'b0;
        bus.req0   = 1'b0;
        bus.req1   = 1'b0;
        bus.we0    = 1'b0;
        bus.we1    = 1'b0;
        bus.addr0  = 32'h0;
        bus.addr1  = 32'h0;
        bus.wdata0 = 32'h0;
        bus.wdata1 = 32'h0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("rst_gnt", 32'({bus.gnt1, bus.gnt0}), 32'd0);
        check("rst_done", 32'({bus.done1, bus.done0}), 32'd0);
        check("rst_err", 32'({bus.err1, bus.err0}), 32'd0);
        check("rst_rdata", bus.rdata, 32'h0);
        check("rst_strobe", 32'({bus.mem_write, bus.mem_read}), 32'd0);
        @(posedge clk);
        #1;
        rst     = 1'b1;
        preload = 1'b0;
    endtask

    // Called just after a posedge while the arbiter sits in IDLE; returns likewise.
    task automatic run_access(input int port, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] exp_rdata,
                              input logic exp_err);
        logic [31:0] onehot;
        logic        ok;
        ok     = ~exp_err;
        onehot = (port == 0) ? 32'd1 : 32'd2;
        if (port == 0) begin
            bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata;
        end else begin
            bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata;
        end
        @(negedge clk);
        check("idle_wr", 32'(bus.mem_write), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("acc_gnt", 32'({bus.gnt1, bus.gnt0}), onehot);
        check("acc_done", 32'({bus.done1, bus.done0}), 32'd0);
        check("acc_wr", 32'(bus.mem_write), 32'(we & ok));
        check("acc_rd", 32'(bus.mem_read), 32'(~we & ok));
        check("acc_addr", bus.mem_addr, addr);
        if (we & ok) check("acc_wdata", bus.mem_wdata, wdata);
        @(posedge clk);
        @(negedge clk);
        check("resp_done", 32'({bus.done1, bus.done0}), onehot);
        check("resp_err", 32'({bus.err1, bus.err0}), exp_err ? onehot : 32'd0);
        check("resp_gnt", 32'({bus.gnt1, bus.gnt0}), 32'd0);
        check("resp_strobe", 32'({bus.mem_write, bus.mem_read}), 32'd0);
        if (!we || exp_err) check("resp_rdata", bus.rdata, exp_rdata);
        @(posedge clk);
        #1;
        if (port == 0) bus.req0 = 1'b0;
        else bus.req1 = 1'b0;
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        preload = 1'b1;
        do_reset();

        // Write then read back through port 0.
        run_access(0, 1'b1, 32'h84, 32'hDEAD_BEEF, 32'h0, 1'b0);
        run_access(0, 1'b0, 32'h84, 32'h0, 32'hDEAD_BEEF, 1'b0);

        // Reset lands in the ACCESS cycle of a write to 0x88.
        bus.req0   = 1'b1;
        bus.we0    = 1'b1;
        bus.addr0  = 32'h88;
        bus.wdata0 = 32'h1234_5678;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_wr", 32'(bus.mem_write), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("midrst_done", 32'({bus.done1, bus.done0}), 32'd0);
        check("midrst_gnt", 32'({bus.gnt1, bus.gnt0}), 32'd0);
        check("midrst_rdata", bus.rdata, 32'h0);
        @(posedge clk);
        #1;
        rst      = 1'b1;
        bus.req0 = 1'b0;
        bus.we0  = 1'b0;

        // Both ports hold requests for word 0; service must alternate starting at port 0.
        bus.req0  = 1'b1;
        bus.req1  = 1'b1;
        bus.addr0 = 32'h80;
        bus.addr1 = 32'h80;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("rr_gnt", 32'({bus.gnt1, bus.gnt0}), (k % 2 == 1) ? 32'd2 : 32'd1);
            @(posedge clk);
            @(negedge clk);
            check("rr_done", 32'({bus.done1, bus.done0}), (k % 2 == 1) ? 32'd2 : 32'd1);
            check("rr_rdata", bus.rdata, 32'h1000_0000);
            @(posedge clk);
        end
        #1;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;

        // The aborted write must have left 0x88 untouched.
        run_access(0, 1'b0, 32'h88, 32'h0, 32'h1000_0002, 1'b0);

        // Out-of-window and misaligned reads on port 1.
        run_access(1, 1'b0, 32'h7C, 32'h0, 32'h0, 1'b1);
        run_access(1, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1);
        run_access(1, 1'b0, 32'h82, 32'h0, 32'h0, 1'b1);
        run_access(1, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b1);

        // Last word is in range, one past is not.
        run_access(0, 1'b1, 32'hFC, 32'hA5A5_0001, 32'h0, 1'b0);
        run_access(0, 1'b0, 32'hFC, 32'h0, 32'hA5A5_0001, 1'b0);
        run_access(0, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1);

        // Address changed after the IDLE edge must be ignored.
        bus.req0  = 1'b1;
        bus.we0   = 1'b0;
        bus.addr0 = 32'h80;
        @(posedge clk);
        #1;
        bus.addr0 = 32'h90;
        @(negedge clk);
        check("latch_addr", bus.mem_addr, 32'h80);
        @(posedge clk);
        @(negedge clk);
        check("latch_done", 32'(bus.done0), 32'd1);
        check("latch_rdata", bus.rdata, 32'h1000_0000);
        @(posedge clk);
        #1;
        bus.req0 = 1'b0;
        @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
